bpsk_rx_frame_ctrl: RTL and testbench

- Sequences the receive path after `bpsk_demodulator_top`: recovers symbol timing from the 1-bit demod output, hunts for a sync word and resolves the BPSK 180° ambiguity.
- Parses a length byte, then emits payload bytes over a valid/ready stream.
- Sits between the demodulator `data_out` and the host/UART byte sink.

---
 rtl/bpsk_rx_pkg.sv | 18 +
 rtl/bpsk_symbol_timing.sv | 49 ++++
 rtl/bpsk_rx_frame_ctrl.sv | 152 +++++++++++++++
 tb/tb_bpsk_rx_frame_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_rx_pkg.sv
// Shared types and default parameters for the BPSK receive frame controller.
package bpsk_rx_pkg;

  localparam int          DEFAULT_SPS       = 80;
  localparam logic [31:0] DEFAULT_SYNC_WORD = 32'h0000_D391;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD
  } rx_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } rx_entry_t;

endpackage

// File: rtl/bpsk_symbol_timing.sv
// Symbol timing recovery: re-phases a free-running symbol counter on every
// demod transition and strobes mid-symbol.
module bpsk_symbol_timing
  import bpsk_rx_pkg::*;
#(
  parameter int SAMPLES_PER_SYMBOL = DEFAULT_SPS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_enable,
  input  logic i_demod_bit,
  output logic o_sample_stb,
  output logic o_sample_bit
);

  localparam int             CW   = $clog2(SAMPLES_PER_SYMBOL);
  localparam logic [CW-1:0] LAST  = CW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [CW-1:0] HALF  = CW'(SAMPLES_PER_SYMBOL / 2);

  logic          r_prev_bit;
  logic [CW-1:0] r_sym_cnt;
  logic          w_edge;

  assign w_edge = (i_demod_bit != r_prev_bit);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_bit <= 1'b0;
      r_sym_cnt  <= '0;
    end else begin
      r_prev_bit <= i_demod_bit;
      if (!i_enable)
        r_sym_cnt <= '0;
      else if (w_edge)
        r_sym_cnt <= CW'(1);
      else if (r_sym_cnt == LAST)
        r_sym_cnt <= '0;
      else
        r_sym_cnt <= r_sym_cnt + 1'b1;
    end
  end

  // The bit sampled is the one held before this cycle's input.
  assign o_sample_stb = i_enable && !w_edge && (r_sym_cnt == HALF);
  assign o_sample_bit = r_prev_bit;

endmodule

// File: rtl/bpsk_rx_frame_ctrl.sv
// Receive frame sequencer: sync hunt with polarity resolution, length parse,
// payload byte assembly into a 2-entry non-stalling output buffer.
module bpsk_rx_frame_ctrl
  import bpsk_rx_pkg::*;
#(
  parameter int          SAMPLES_PER_SYMBOL = DEFAULT_SPS,
  parameter int          SYNC_BITS          = 16,
  parameter logic [31:0] SYNC_WORD          = DEFAULT_SYNC_WORD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       demod_bit,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic       frame_start,
  output logic       frame_done,
  output logic       overflow,
  output logic       busy
);

  localparam logic [SYNC_BITS-1:0] SYNC = SYNC_WORD[SYNC_BITS-1:0];

  rx_state_t            r_state;
  logic [SYNC_BITS-2:0] r_shift;
  logic                 r_invert;
  logic [2:0]           r_bit_cnt;
  logic [6:0]           r_byte_sr;
  logic [7:0]           r_remain;
  logic                 r_frame_start, r_frame_done, r_overflow;

  rx_entry_t            r_fifo [2];
  logic                 r_rd_ptr, r_wr_ptr;
  logic [1:0]           r_count;

  logic                 w_stb, w_raw_bit, w_bit;
  logic [SYNC_BITS-1:0] w_shift_nxt;
  logic [7:0]           w_byte_nxt;
  logic                 w_push, w_pop, w_push_ok, w_drop, w_last;
  rx_entry_t            w_head;

  bpsk_symbol_timing #(.SAMPLES_PER_SYMBOL(SAMPLES_PER_SYMBOL)) u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_enable     (enable),
    .i_demod_bit  (demod_bit),
    .o_sample_stb (w_stb),
    .o_sample_bit (w_raw_bit)
  );

  // Sync hunting sees raw polarity; everything after sync is corrected.
  assign w_bit       = (r_state == HUNT) ? w_raw_bit : (w_raw_bit ^ r_invert);
  assign w_shift_nxt = {r_shift, w_raw_bit};
  assign w_byte_nxt  = {r_byte_sr, w_bit};
  assign w_last      = (r_remain == 8'd1);

  assign w_push    = w_stb && (r_state == PAYLOAD) && (r_bit_cnt == 3'd7);
  assign w_pop     = byte_valid && byte_ready;
  assign w_push_ok = w_push && ((r_count != 2'd2) || w_pop);
  assign w_drop    = w_push && !w_push_ok;

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state       <= HUNT;
      r_shift       <= '0;
      r_invert      <= 1'b0;
      r_bit_cnt     <= '0;
      r_byte_sr     <= '0;
      r_remain      <= '0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (rst) r_overflow <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_drop) r_overflow <= 1'b1;
      if (w_stb) begin
        unique case (r_state)
          HUNT: begin
            r_shift <= w_shift_nxt[SYNC_BITS-2:0];
            if ((w_shift_nxt == SYNC) || (w_shift_nxt == ~SYNC)) begin
              r_invert      <= (w_shift_nxt != SYNC);
              r_state       <= LEN;
              r_bit_cnt     <= '0;
              r_frame_start <= 1'b1;
              r_overflow    <= 1'b0;
            end
          end
          LEN: begin
            r_byte_sr <= w_byte_nxt[6:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_remain <= w_byte_nxt;
              if (w_byte_nxt == 8'd0) begin
                r_frame_done <= 1'b1;
                r_state      <= HUNT;
                r_shift      <= '0;
              end else begin
                r_state <= PAYLOAD;
              end
            end
          end
          PAYLOAD: begin
            r_byte_sr <= w_byte_nxt[6:0];
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) begin
              r_remain <= r_remain - 1'b1;
              if (w_last) begin
                r_frame_done <= 1'b1;
                r_state      <= HUNT;
                r_shift      <= '0;
              end
            end
          end
          default: r_state <= HUNT;
        endcase
      end
    end
  end

  // Pop frees a slot before the push lands, so a full buffer drained this
  // cycle still accepts the new byte.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)     r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_push_ok) - 2'(w_pop);
    end
  end

  // NOTE: buffer storage carries no reset; occupancy is tracked by the
  // pointers and the output is masked while empty.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_fifo[r_wr_ptr] <= '{data: w_byte_nxt, last: w_last};
  end

  assign w_head      = r_fifo[r_rd_ptr];
  assign byte_valid  = (r_count != 2'd0);
  assign byte_out    = byte_valid ? w_head.data : 8'd0;
  assign byte_last   = byte_valid && w_head.last;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign overflow    = r_overflow;
  assign busy        = (r_state != HUNT);

endmodule

// File: tb/tb_bpsk_rx_frame_ctrl.sv
// Bench for bpsk_rx_frame_ctrl: frames are built bit-by-bit from their
// content, driven at symbol rate, and decoded bytes compared to a queue.
module tb_bpsk_rx_frame_ctrl;

  localparam int          SPS  = 80;
  localparam logic [15:0] SYNC = 16'hD391;
  localparam int          PRE  = 18;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       demod_bit = 1'b0;
  logic       byte_ready = 1'b1;
  logic [7:0] byte_out;
  logic       byte_valid, byte_last, frame_start, frame_done, overflow, busy;

  int n_total = 0, n_bad = 0;
  int n_start = 0, n_done = 0, n_valid_cyc = 0, n_pop = 0;
  int cyc = 0, start_cyc = 0, since_edge = 0;
  logic mon_prev = 1'b0;
  bit chk_done_last = 0, chk_len0 = 0, chk_stb = 0, rand_ready = 0, cur_inv = 0;
  int exp_q[$];
  bit tx_q[$];

  always #5 clk = ~clk;

  bpsk_rx_frame_ctrl #(
    .SAMPLES_PER_SYMBOL(SPS),
    .SYNC_BITS(16),
    .SYNC_WORD(32'h0000_D391)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .demod_bit(demod_bit),
    .byte_out(byte_out), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .byte_last(byte_last), .frame_start(frame_start), .frame_done(frame_done),
    .overflow(overflow), .busy(busy)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) byte_ready = ($urandom_range(3) != 0);
  endtask

  // Preamble, sync, length, payload, two idle bits; queues the bytes the
  // sink should see (first `keep` bytes of the payload).
  task automatic build_frame(input int len, input bit inv, input int keep, input bit fixed);
    logic [15:0] s;
    logic [7:0]  l8;
    logic [7:0]  b;
    s  = SYNC;
    l8 = 8'(len);
    tx_q.delete();
    for (int i = 0; i < PRE; i++) tx_q.push_back(((i % 2) == 0) ^ inv);
    for (int i = 15; i >= 0; i--) tx_q.push_back(s[i] ^ inv);
    for (int i = 7; i >= 0; i--)  tx_q.push_back(l8[i] ^ inv);
    for (int k = 0; k < len; k++) begin
      b = fixed ? 8'(17 * (k + 1)) : 8'($urandom_range(255));
      for (int i = 7; i >= 0; i--) tx_q.push_back(b[i] ^ inv);
      if (k < keep) exp_q.push_back(((k == len - 1) ? 256 : 0) + int'(b));
    end
    tx_q.push_back(1'b1 ^ inv);
    tx_q.push_back(1'b0 ^ inv);
    cur_inv = inv;
  endtask

  // Symbol boundaries sit on an 80-cycle grid, each displaced by up to
  // +/-5 cycles when jitter is on (displacements do not accumulate).
  task automatic send_bits(input int nbits, input bit jitter);
    int jp, jn, n;
    jp = 0;
    for (int i = 0; i < nbits; i++) begin
      jn = (jitter && i != nbits - 1) ? int'($urandom_range(10)) - 5 : 0;
      n  = SPS + jn - jp;
      demod_bit = tx_q[i];
      repeat (n) tick();
      jp = jn;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (demod_bit != mon_prev) since_edge = 0;
    else since_edge++;
    mon_prev = demod_bit;
    if (chk_stb && dut.u_timing.o_sample_stb)
      check("stb_phase", since_edge % SPS, SPS / 2);
    if (byte_valid) n_valid_cyc++;
    if (frame_start) begin
      n_start++;
      start_cyc = cyc;
      check("invert", int'(dut.r_invert), int'(cur_inv));
    end
    if (frame_done) begin
      n_done++;
      if (chk_done_last) check("done_with_last", int'({byte_valid, byte_last}), 3);
      if (chk_len0) check("len0_gap", cyc - start_cyc, 8 * SPS);
    end
    if (byte_valid && byte_ready) begin
      n_pop++;
      check("byte_expected", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("byte", int'({byte_last, byte_out}), exp_q.pop_front());
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0, v0, p0, l;
    repeat (3) tick();
    check("rst_valid",    byte_valid,  0);
    check("rst_byte",     byte_out,    0);
    check("rst_last",     byte_last,   0);
    check("rst_start",    frame_start, 0);
    check("rst_done",     frame_done,  0);
    check("rst_overflow", overflow,    0);
    check("rst_busy",     busy,        0);
    rst = 1'b0;
    tick();

    // Plain and fully inverted frames with 0x11,0x22,0x33.
    chk_done_last = 1;
    for (int inv = 0; inv < 2; inv++) begin
      s0 = n_start; d0 = n_done; v0 = n_valid_cyc;
      build_frame(3, 1'(inv), 3, 1);
      send_bits(tx_q.size(), 0);
      check("fix_start",        n_start - s0,     1);
      check("fix_done",         n_done - d0,      1);
      check("fix_valid_cycles", n_valid_cyc - v0, 3);
      check("fix_drained",      exp_q.size(),     0);
      check("fix_busy",         busy,             0);
    end
    chk_done_last = 0;

    // Sink stalled: two bytes held, two dropped.
    byte_ready = 1'b0;
    d0 = n_done; p0 = n_pop;
    build_frame(4, 0, 2, 0);
    send_bits(tx_q.size(), 0);
    check("ovf_done",     n_done - d0, 1);
    check("ovf_flag",     overflow,    1);
    check("ovf_held",     byte_valid,  1);
    byte_ready = 1'b1;
    repeat (4) tick();
    check("ovf_drain_count", n_pop - p0,   2);
    check("ovf_drained",     exp_q.size(), 0);
    check("ovf_empty",       byte_valid,   0);
    check("ovf_sticky",      overflow,     1);

    // Zero-length frame.
    chk_len0 = 1;
    s0 = n_start; d0 = n_done; v0 = n_valid_cyc;
    build_frame(0, 0, 0, 0);
    send_bits(tx_q.size(), 0);
    chk_len0 = 0;
    check("len0_start",   n_start - s0,     1);
    check("len0_done",    n_done - d0,      1);
    check("len0_novalid", n_valid_cyc - v0, 0);
    check("len0_ovf_clr", overflow,         0);

    // Jittered edges, random payloads and polarity, random sink readiness.
    chk_stb = 1; rand_ready = 1;
    d0 = n_done;
    for (int f = 0; f < 3; f++) begin
      l = $urandom_range(3, 1);
      build_frame(l, 1'($urandom_range(1)), l, 0);
      send_bits(tx_q.size(), 1);
    end
    rand_ready = 0; chk_stb = 0; byte_ready = 1'b1;
    repeat (4) tick();
    check("jit_done",     n_done - d0,  3);
    check("jit_drained",  exp_q.size(), 0);
    check("jit_overflow", overflow,     0);

    // Abort mid-payload with one byte buffered, by enable then by rst.
    for (int m = 0; m < 2; m++) begin
      byte_ready = 1'b0;
      s0 = n_start; d0 = n_done;
      build_frame(3, 0, 1, 0);
      send_bits(PRE + 16 + 8 + 8 + 3, 0);
      check("abort_buffered", byte_valid, 1);
      check("abort_busy_pre", busy,       1);
      if (m == 0) enable = 1'b0;
      else rst = 1'b1;
      tick();
      check("abort_valid", byte_valid, 0);
      check("abort_busy",  busy,       0);
      enable = 1'b1; rst = 1'b0; byte_ready = 1'b1;
      exp_q.delete();
      l = $urandom_range(2, 1);
      build_frame(l, 1'($urandom_range(1)), l, 0);
      send_bits(tx_q.size(), 0);
      check("abort_next_start",   n_start - s0, 2);
      check("abort_next_done",    n_done - d0,  1);
      check("abort_next_drained", exp_q.size(), 0);
      check("abort_next_busy",    busy,         0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
